// File: rtl/seq_divider_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU types and constants: divider FSM states, MIPS
//            funct codes and the counter-width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ============================================================================
// Module   : seq_divider_if
// Purpose  : Request/result bundle between pipeline control and the divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seq_divider_if #(
    parameter int N = 32
);
    logic         start;
    logic         is_signed;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ============================================================================
// Module   : div_step
// Purpose  : One restoring-division step: trial subtract, keep or restore.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_step #(
    parameter int N = 32
) (
    input  wire logic [N:0]   a_shift_i,
    input  wire logic [N-1:0] divisor_i,
    output logic      [N:0]   a_next_o,
    output logic              q_bit_o
);
    // Extra MSB acts as the borrow: the shifted partial remainder can exceed 2^N.
    logic [N+1:0] w_diff;

    assign w_diff   = {1'b0, a_shift_i} - {2'b00, divisor_i};
    assign q_bit_o  = ~w_diff[N+1];
    assign a_next_o = q_bit_o ? w_diff[N:0] : a_shift_i;
endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module   : seq_divider
// Purpose  : Iterative restoring DIV/DIVU, one quotient bit per clock.
//            Optional macro DIV_EARLY_OUT_EN skips iteration when |a| < |b|.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_divider
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    seq_divider_if.slave   bus
);
    localparam int CW = cnt_width(N);

    state_t          state_q;
    logic [N-1:0]    dividend_q, divisor_q;
    logic            signed_q;
    logic [N:0]      a_q;
    logic [N-1:0]    q_q;
    logic [CW-1:0]   cnt_q;
    logic            q_neg_q, r_neg_q, dz_q;
    logic            busy_q, done_q, dvz_q;
    logic [N-1:0]    quot_q, rem_q;

    logic [N-1:0]    w_mag_dvd, w_mag_dvs;
    logic [N:0]      w_a_shift, w_a_next;
    logic            w_q_bit;

    // abs(MIN) wraps back to MIN, which is the correct unsigned magnitude.
    assign w_mag_dvd = (signed_q && dividend_q[N-1]) ? -dividend_q : dividend_q;
    assign w_mag_dvs = (signed_q && divisor_q[N-1])  ? -divisor_q  : divisor_q;
    assign w_a_shift = {a_q[N-1:0], q_q[N-1]};

    div_step #(.N(N)) u_div_step (
        .a_shift_i (w_a_shift),
        .divisor_i (w_mag_dvs),
        .a_next_o  (w_a_next),
        .q_bit_o   (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            a_q        <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dvz_q      <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        dividend_q <= bus.dividend;
                        divisor_q  <= bus.divisor;
                        signed_q   <= bus.is_signed;
                        busy_q     <= 1'b1;
                        dvz_q      <= 1'b0;
                        state_q    <= PREP;
                    end
                end
                PREP: begin
                    q_neg_q <= signed_q & (dividend_q[N-1] ^ divisor_q[N-1]);
                    r_neg_q <= signed_q & dividend_q[N-1];
                    dz_q    <= 1'b0;
                    if (divisor_q == '0) begin
                        // MIPS leaves the result raw on divide-by-zero: no sign fix-up.
                        q_neg_q <= 1'b0;
                        r_neg_q <= 1'b0;
                        dz_q    <= 1'b1;
                        q_q     <= '1;
                        a_q     <= {1'b0, dividend_q};
                        state_q <= FIX;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (w_mag_dvd < w_mag_dvs) begin
                        q_q     <= '0;
                        a_q     <= {1'b0, w_mag_dvd};
                        state_q <= FIX;
                    end
`endif
                    else begin
                        a_q     <= '0;
                        q_q     <= w_mag_dvd;
                        cnt_q   <= CW'(N - 1);
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    a_q <= w_a_next;
                    q_q <= {q_q[N-2:0], w_q_bit};
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FIX: begin
                    quot_q  <= q_neg_q ? -q_q : q_q;
                    rem_q   <= r_neg_q ? -a_q[N-1:0] : a_q[N-1:0];
                    dvz_q   <= dz_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dvz_q;
endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Directed plus random checks of seq_divider against an
//            arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; SV truncates toward zero and the
    // remainder takes the dividend's sign, matching DIV/DIVU.
    task automatic ref_model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r,
                             output logic dz, output int lat);
        longint va, vb, vq, vr, ma, mb;
        va = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        vb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        ma = (va < 0) ? -va : va;
        mb = (vb < 0) ? -vb : vb;
        if (vb == 0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 2;
        end else begin
            vq = va / vb;
            vr = va % vb;
            q = vq[31:0]; r = vr[31:0]; dz = 1'b0; lat = N + 2;
`ifdef DIV_EARLY_OUT_EN
            if (ma < mb) lat = 2;
`endif
        end
    endtask

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input bit intrude, input string tag);
        logic [31:0] eq, er;
        logic        edz;
        int          elat, edges;
        bit          busy_ok;
        ref_model(sgn, a, b, eq, er, edz, elat);
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = sgn; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.dividend = $urandom; bus.divisor = $urandom; bus.is_signed = 1'($urandom);
        check({tag, ":busy_rise"}, 64'(bus.busy), 64'd1);
        check({tag, ":dz_clear"}, 64'(bus.div_by_zero), 64'd0);
        edges = 0; busy_ok = 1'b1;
        while (!bus.done && edges < 100) begin
            if (intrude && edges == 9) begin
                bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
            end
            @(posedge clk); #1;
            edges++;
            if (intrude && edges == 10) bus.start = 1'b0;
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end
        check({tag, ":latency"}, 64'(edges), 64'(elat));
        check({tag, ":quotient"}, 64'(bus.quotient), 64'(eq));
        check({tag, ":remainder"}, 64'(bus.remainder), 64'(er));
        check({tag, ":div_by_zero"}, 64'(bus.div_by_zero), 64'(edz));
        check({tag, ":busy_fall"}, 64'(bus.busy), 64'd0);
        check({tag, ":busy_held"}, 64'(busy_ok), 64'd1);
        @(posedge clk); #1;
        check({tag, ":done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, ":q_hold"}, 64'(bus.quotient), 64'(eq));
    endtask

    initial begin
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:busy", 64'(bus.busy), 64'd0);
        check("reset:done", 64'(bus.done), 64'd0);
        check("reset:quotient", 64'(bus.quotient), 64'd0);
        check("reset:remainder", 64'(bus.remainder), 64'd0);
        check("reset:div_by_zero", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 1'b0, "u100_7");
        run_op(1'b1, -32'sd7, 32'd2, 1'b0, "s-7_2");
        run_op(1'b1, 32'd7, -32'sd2, 1'b0, "s7_-2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "sMIN_-1");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "uMIN_FFFF");
        run_op(1'b0, 32'd5, 32'd0, 1'b0, "u5_0");
        run_op(1'b0, 32'd9, 32'd3, 1'b0, "u9_3");
        run_op(1'b1, 32'd5, 32'd0, 1'b0, "s5_0");
        run_op(1'b1, -32'sd5, 32'd0, 1'b0, "s-5_0");
        run_op(1'b1, 32'd9, 32'd3, 1'b0, "s9_3");
        run_op(1'b0, 32'd1000, 32'd3, 1'b1, "busy_start");

        // Asynchronous reset in the middle of iteration.
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst:busy", 64'(bus.busy), 64'd0);
        check("async_rst:done", 64'(bus.done), 64'd0);
        check("async_rst:quotient", 64'(bus.quotient), 64'd0);
        check("async_rst:remainder", 64'(bus.remainder), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(1'b0, 32'd1000, 32'd3, 1'b0, "after_rst");

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            logic        s;
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = -32'($urandom_range(1, 15));
                2:       b = a + 32'($urandom_range(1, 3));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            s = 1'($urandom);
            run_op(s, a, b, 1'b0, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
